// File: rtl/tc08_read_decoder.sv
// tc08_read_decoder: TU55 read front end that qualifies head lines and decodes marks and 12-bit words.
module tc08_read_decoder #(
  parameter logic [5:0]  MARK_SYNC  = 6'o32,
  parameter logic [5:0]  MARK_DATA  = 6'o70,
  parameter logic [5:0]  MARK_BLOCK = 6'o26,
  parameter logic [5:0]  MARK_ENDZ  = 6'o22,
  parameter logic [31:0] STALL_CLKS = 32'd20000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        rev,
  input  logic        t_trk_rd_pos,
  input  logic        t_trk_rd_neg,
  input  logic        rdmk_rd_pos,
  input  logic        rdmk_rd_neg,
  input  logic        rdd_00_rd_pos,
  input  logic        rdd_00_rd_neg,
  input  logic        rdd_01_rd_pos,
  input  logic        rdd_01_rd_neg,
  input  logic        rdd_02_rd_pos,
  input  logic        rdd_02_rd_neg,
  output logic        line_stb,
  output logic [5:0]  mark_code,
  output logic        mark_stb,
  output logic [11:0] word,
  output logic        word_stb,
  output logic        synced,
  output logic        stalled
);
  typedef enum logic {HUNT, SYNCED} state_t;
  state_t      state;
  logic        a_t_pos, a_t_neg, a_mk_pos, a_mk_neg, b_t_pos, rev_q;
  logic [2:0]  a_d_pos, a_d_neg, d;
  logic [5:0]  msr, msr_n;
  logic [11:0] wsr, wsr_n;
  logic [1:0]  lcnt;
  logic [2:0]  mph;
  logic [31:0] scnt;
  logic        line, mk, rev_chg, stall_hit;

  assign line      = a_t_pos & ~b_t_pos & (a_t_pos ^ a_t_neg);
  assign mk        = (a_mk_pos ^ a_mk_neg) & (a_mk_pos ^ rev);
  assign d         = (a_d_pos ^ a_d_neg) & (a_d_pos ^ {3{rev}});
  assign msr_n     = {msr[4:0], mk};
  assign wsr_n     = {wsr[8:0], d};
  assign rev_chg   = rev ^ rev_q;
  assign stall_hit = ~line & (scnt == STALL_CLKS - 32'd1);
  assign synced    = (state == SYNCED);

  // Head inputs registered twice; stage B only needs the timing level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      a_t_pos  <= 1'b0;
      a_t_neg  <= 1'b0;
      a_mk_pos <= 1'b0;
      a_mk_neg <= 1'b0;
      a_d_pos  <= '0;
      a_d_neg  <= '0;
      b_t_pos  <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      a_t_pos  <= t_trk_rd_pos;
      a_t_neg  <= t_trk_rd_neg;
      a_mk_pos <= rdmk_rd_pos;
      a_mk_neg <= rdmk_rd_neg;
      a_d_pos  <= {rdd_00_rd_pos, rdd_01_rd_pos, rdd_02_rd_pos};
      a_d_neg  <= {rdd_00_rd_neg, rdd_01_rd_neg, rdd_02_rd_neg};
      b_t_pos  <= a_t_pos;
      rev_q    <= rev;
    end

  // Stall watchdog: counts clocks since the last line, saturating at STALL_CLKS.
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      scnt    <= '0;
      stalled <= 1'b0;
    end else if (line) begin
      scnt    <= '0;
      stalled <= 1'b0;
    end else begin
      if (scnt != STALL_CLKS) scnt <= scnt + 32'd1;
      if (stall_hit) stalled <= 1'b1;
    end

  // Line shift registers and HUNT/SYNCED framing; rev change and stall abort framing.
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state     <= HUNT;
      msr       <= '0;
      wsr       <= '0;
      lcnt      <= '0;
      mph       <= '0;
      mark_code <= '0;
      word      <= '0;
      line_stb  <= 1'b0;
      mark_stb  <= 1'b0;
      word_stb  <= 1'b0;
    end else begin
      line_stb <= 1'b0;
      mark_stb <= 1'b0;
      word_stb <= 1'b0;
      if (rev_chg) begin
        state <= HUNT;
        lcnt  <= '0;
        mph   <= '0;
        msr   <= '0;
        wsr   <= '0;
      end else if (stall_hit) begin
        state <= HUNT;
        msr   <= '0;
        wsr   <= '0;
      end else if (line) begin
        line_stb <= 1'b1;
        msr      <= msr_n;
        wsr      <= wsr_n;
        if (state == HUNT) begin
          if (msr_n == MARK_SYNC) begin
            mark_stb  <= 1'b1;
            mark_code <= msr_n;
            state     <= SYNCED;
            lcnt      <= '0;
            mph       <= '0;
          end else if (msr_n == MARK_BLOCK || msr_n == MARK_ENDZ) begin
            mark_stb  <= 1'b1;
            mark_code <= msr_n;
          end
        end else begin
          lcnt <= lcnt + 2'd1;
          mph  <= (mph == 3'd5) ? 3'd0 : mph + 3'd1;
          if (lcnt == 2'd3) begin
            word_stb <= 1'b1;
            word     <= wsr_n;
          end
          if (mph == 3'd5 && msr_n != MARK_DATA) begin
            mark_stb  <= 1'b1;
            mark_code <= msr_n;
            state     <= HUNT;
          end
        end
      end
    end
endmodule

// File: tb/tb_tc08_read_decoder.sv
// tb_tc08_read_decoder: random and directed stimulus against a line-level reference model.
module tb_tc08_read_decoder;
  localparam int S = 20000;
  typedef struct packed {logic tp, tn, mp, mn; logic [2:0] dp, dn;} hv_t;

  logic clk = 0, rst_l = 0, rev = 0;
  logic tp = 0, tn = 0, mp = 0, mn = 0;
  logic [2:0] dp = '0, dn = '0;
  logic line_stb, mark_stb, word_stb, synced, stalled;
  logic [5:0] mark_code;
  logic [11:0] word;
  int checks = 0, errors = 0;

  tc08_read_decoder dut (
    .clk(clk), .rst_l(rst_l), .rev(rev),
    .t_trk_rd_pos(tp), .t_trk_rd_neg(tn),
    .rdmk_rd_pos(mp), .rdmk_rd_neg(mn),
    .rdd_00_rd_pos(dp[2]), .rdd_00_rd_neg(dn[2]),
    .rdd_01_rd_pos(dp[1]), .rdd_01_rd_neg(dn[1]),
    .rdd_02_rd_pos(dp[0]), .rdd_02_rd_neg(dn[0]),
    .line_stb(line_stb), .mark_code(mark_code), .mark_stb(mark_stb),
    .word(word), .word_stb(word_stb), .synced(synced), .stalled(stalled)
  );

  always #5 clk = ~clk;

  // reference model state
  hv_t h1 = '0, h2 = '0;
  logic m_revq = 0, m_sync = 0;
  int win = 0, acc = 0, n = 0, scnt = 0;
  logic e_line = 0, e_mark = 0, e_word = 0, e_stall = 0;
  logic [5:0] e_code = '0;
  logic [11:0] e_wrd = '0;
  // observation log
  logic [5:0] mq[$];
  logic [11:0] wq[$];
  int cyc = 0, both = 0, nls = 0, last_line = 0, stall_cyc = -1;
  logic prev_st = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // model step per clock edge, then compare every cycle
  initial begin
    hv_t cur;
    logic ln, mk, chg, hit;
    int dv;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {tp, tn, mp, mn, dp, dn};
      if (!rst_l) begin
        h1 = '0; h2 = '0; m_revq = 0; m_sync = 0; win = 0; acc = 0; n = 0; scnt = 0;
        e_line = 0; e_mark = 0; e_word = 0; e_stall = 0; e_code = '0; e_wrd = '0;
      end else begin
        ln = h1.tp && !h1.tn && !h2.tp;
        mk = (h1.mp != h1.mn) && (h1.mp != rev);
        dv = 0;
        for (int i = 2; i >= 0; i--) dv = dv * 2 + int'((h1.dp[i] != h1.dn[i]) && (h1.dp[i] != rev));
        chg = (rev != m_revq);
        hit = 0;
        e_line = 0; e_mark = 0; e_word = 0;
        if (ln) begin scnt = 0; e_stall = 0; end
        else if (scnt < S) begin
          scnt++;
          if (scnt == S) begin e_stall = 1; hit = 1; end
        end
        if (chg) begin m_sync = 0; n = 0; win = 0; acc = 0; end
        else if (hit) begin m_sync = 0; win = 0; acc = 0; end
        else if (ln) begin
          e_line = 1;
          win = (win * 2 + int'(mk)) % 64;
          acc = (acc * 8 + dv) % 4096;
          if (!m_sync) begin
            if (win == 'o32) begin e_mark = 1; e_code = 6'(win); m_sync = 1; n = 0; end
            else if (win == 'o26 || win == 'o22) begin e_mark = 1; e_code = 6'(win); end
          end else begin
            n++;
            if (n % 4 == 0) begin e_word = 1; e_wrd = 12'(acc); end
            if (n % 6 == 0 && win != 'o70) begin e_mark = 1; e_code = 6'(win); m_sync = 0; end
          end
        end
        h2 = h1; h1 = cur; m_revq = rev;
      end
      checks++;
      if ({line_stb, mark_stb, mark_code, word_stb, word, synced, stalled} !==
          {e_line, e_mark, e_code, e_word, e_wrd, m_sync, e_stall}) begin
        errors++;
        $display("FAIL outputs cyc %0d actual line=%b mark=%b code=%o wstb=%b word=%o sync=%b stall=%b required line=%b mark=%b code=%o wstb=%b word=%o sync=%b stall=%b",
                 cyc, line_stb, mark_stb, mark_code, word_stb, word, synced, stalled,
                 e_line, e_mark, e_code, e_word, e_wrd, m_sync, e_stall);
      end
      if (mark_stb) mq.push_back(mark_code);
      if (word_stb) wq.push_back(word);
      if (mark_stb && word_stb) both++;
      if (line_stb) begin nls++; last_line = cyc; end
      if (stalled && !prev_st) stall_cyc = cyc;
      prev_st = stalled;
    end
  end

  task automatic tick(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  // bad[3]=mark pair invalid, bad[2:0]=data pairs invalid, bad[4]=timing pair invalid
  task automatic put_line(input logic mk, input logic [2:0] d, input logic [4:0] bad, input int hi, input int lo);
    logic b;
    b = 1'($urandom);
    mp = bad[3] ? b : mk ^ rev;
    mn = bad[3] ? b : ~(mk ^ rev);
    for (int i = 0; i < 3; i++) begin
      b = 1'($urandom);
      dp[i] = bad[i] ? b : d[i] ^ rev;
      dn[i] = bad[i] ? b : ~(d[i] ^ rev);
    end
    tp = 1; tn = bad[4];
    tick(hi);
    tp = 0; tn = 1;
    tick(lo);
  endtask

  task automatic line(input logic mk, input logic [2:0] d);
    put_line(mk, d, 5'd0, 2, 2);
  endtask

  task automatic sync_pat();
    logic [5:0] p;
    p = 6'o32;
    for (int i = 5; i >= 0; i--) line(p[i], 3'd0);
  endtask

  task automatic two_words();
    logic [7:0] m;
    logic [23:0] dd;
    m = 8'b11100011;
    dd = 24'o12345670;
    for (int i = 7; i >= 0; i--) line(m[i], dd[i*3 +: 3]);
  endtask

  initial begin
    int b0, n0, w0;
    @(negedge clk); #1;
    tick(2);
    rst_l = 1;
    tick(2);
    // forward sync and two words
    mq.delete(); wq.delete();
    sync_pat();
    chk("fwd_synced", 32'(synced), 1);
    chk("fwd_mark_cnt", mq.size(), 1);
    chk("fwd_mark_code", mq.size() > 0 ? 32'(mq[0]) : 32'hffffffff, 'o32);
    two_words();
    chk("fwd_word_cnt", wq.size(), 2);
    chk("fwd_word0", wq.size() > 0 ? 32'(wq[0]) : 32'hffffffff, 'o1234);
    chk("fwd_word1", wq.size() > 1 ? 32'(wq[1]) : 32'hffffffff, 'o5670);
    chk("fwd_still_synced", 32'(synced), 1);
    // boundary mark 6'o73 coinciding with a word
    b0 = both;
    line(1, 3'd7); line(0, 3'd7); line(1, 3'd7); line(1, 3'd7);
    chk("bnd_both", both - b0, 1);
    chk("bnd_code", mq.size() > 0 ? 32'(mq[$]) : 32'hffffffff, 'o73);
    chk("bnd_word", wq.size() > 0 ? 32'(wq[$]) : 32'hffffffff, 'o7777);
    chk("bnd_hunt", 32'(synced), 0);
    // async reset mid-stream
    sync_pat();
    chk("pre_rst_synced", 32'(synced), 1);
    line(1, 3'd5);
    tp = 1; tn = 0;
    rst_l = 0;
    #1;
    chk("rst_async", {line_stb, mark_stb, mark_code, word_stb, word, synced, stalled}, 0);
    tick(3);
    tp = 0; tn = 1;
    rst_l = 1;
    tick(2);
    chk("rst_hold", {mark_code, word, synced, stalled}, 0);
    // reverse direction: complemented stream decodes identically
    rev = 1;
    tick(3);
    mq.delete(); wq.delete();
    sync_pat();
    chk("rev_mark_code", mq.size() > 0 ? 32'(mq[0]) : 32'hffffffff, 'o32);
    two_words();
    chk("rev_word0", wq.size() > 0 ? 32'(wq[0]) : 32'hffffffff, 'o1234);
    chk("rev_word1", wq.size() > 1 ? 32'(wq[1]) : 32'hffffffff, 'o5670);
    line(1, 3'd1); line(1, 3'd2);
    rev = 0;
    tick(2);
    chk("revchg_hunt", 32'(synced), 0);
    w0 = wq.size();
    line(1, 3'd3); line(1, 3'd4);
    chk("revchg_no_word", wq.size() - w0, 0);
    // idle heads: every pair invalid, timing levels toggle together
    n0 = nls;
    mp = 0; mn = 0; dp = '0; dn = '0;
    repeat (10) begin
      tp = 1; tn = 1; tick(2);
      tp = 0; tn = 0; tick(2);
    end
    chk("idle_no_line", nls - n0, 0);
    // stall
    tn = 1;
    sync_pat();
    tick(S + 5);
    chk("stall_exact", stall_cyc - last_line, S);
    chk("stall_flag", 32'(stalled), 1);
    chk("stall_hunt", 32'(synced), 0);
    line(0, 3'd0);
    chk("stall_clear", 32'(stalled), 0);
    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: put_line(1'($urandom), 3'($urandom),
                             ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
                             $urandom_range(1, 3), $urandom_range(1, 3));
        4, 5, 6: begin
          sync_pat();
          repeat ($urandom_range(1, 3)) begin
            logic [5:0] m;
            m = 6'o70;
            if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 5)] ^= 1'b1;
            for (int i = 5; i >= 0; i--) line(m[i], 3'($urandom));
          end
        end
        7: begin rev = ~rev; tick($urandom_range(1, 3)); end
        8: tick($urandom_range(1, 6));
        default: put_line(1'($urandom), 3'($urandom), 5'b10000, 2, 2);
      endcase
    end
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end
endmodule
